pc_branch_unit: RTL and testbench
=================================

Name: pc_branch_unit

Overview:
- Sequential program-counter and branch-resolution block for the single-cycle processor.
- Sits downstream of the 32-bit `equals` comparator and consumes its one-bit equality result.
- Each cycle it resolves BEQ, BNE, jump and halt decode flags into the next fetch address, and tracks retired instructions.
- Only clocked state in the fetch path; instruction memory is addressed directly from pc.

Parameters:
- WIDTH, 32, datapath and PC width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_WIDTH, 32, width of the retire counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  holds PC, state and counter when 1.
- isBranchEq  input  1  decoded BEQ.
- isBranchNe  input  1  decoded BNE.
- isJump  input  1  decoded J.
- isHalt  input  1  decoded HALT.
- eqIn  input  1  equality result from the `equals` comparator for the current instruction.
- offset  input  WIDTH  sign-extended word offset from the immediate field.
- target  input  26  jump target field.
- pc  output  WIDTH  current fetch address.
- pcPlus4  output  WIDTH  pc+4, combinational, wraps mod 2^WIDTH.
- fetchValid  output  1  1 when pc addresses a live instruction.
- taken  output  1  redirect (branch or jump) occurs this cycle.
- halted  output  1  in HALTED state.
- retireCount  output  CNT_WIDTH  instructions retired since reset.

Behaviour:
- Reset, asynchronous on rst_n=0 regardless of clk:
  - state=BOOT, pc=RESET_PC, retireCount=0.
  - fetchValid=0, taken=0, halted=0.
  - Reset asserted mid-run aborts immediately; no partial update survives.
- States:
  - BOOT: first rising edge after rst_n deasserts moves to RUN. pc unchanged; stall ignored; one-cycle fetch bubble.
  - RUN: fetchValid=1. If stall=1, everything holds and taken=0. Otherwise next pc is chosen by priority:
    1. isHalt: pc holds, go to HALTED.
    2. isJump: pc={pcPlus4[31:28], target, 2'b00}.
    3. isBranchEq & eqIn: pc=pcPlus4+(offset<<2).
    4. isBranchNe & ~eqIn: pc=pcPlus4+(offset<<2).
    5. Otherwise pc=pcPlus4.
  - HALTED: pc frozen, fetchValid=0, halted=1. Only rst_n exits.
- Flag conflicts: simultaneous isBranchEq and isBranchNe resolve by the priority list (BEQ wins); isJump overrides both.
- taken: combinational.
  - Equals state==RUN & ~stall & ~isHalt & (isJump | isBranchEq&eqIn | isBranchNe&~eqIn).
  - Forced to 0 in BOOT and HALTED.
- Arithmetic:
  - All adds are WIDTH-bit and wrap silently; no overflow flag.
  - Negative offsets are two's complement: offset=32'hFFFF_FFFF from pc=0x10 gives 0x10.
- retireCount:
  - Increments by 1 on each RUN edge with stall=0, including the halt instruction.
  - Saturates at all-ones; never wraps.
- Latency: a redirect is visible on pc one edge after the decode flags are sampled; no delay slot.

Test Plan:
- Reset/boot: hold rst_n=0 for 3 cycles, release. Required:
  - pc=0x0, fetchValid=0 for 1 cycle.
  - Then fetchValid=1 and pc steps 0x0→0x4→0x8 with no flags set.
  - retireCount=2 after those two steps.
- BEQ taken vs. not taken, at pc=0x8 with isBranchEq=1 and offset=3:
  - eqIn=1 → taken=1, next pc=0x18.
  - Repeat at pc=0x8 with eqIn=0 → taken=0, next pc=0xC.
- BNE backward: at pc=0x20 with isBranchNe=1, eqIn=0, offset=32'hFFFF_FFFC → next pc=0x14. With eqIn=1 → next pc=0x24.
- Jump and priority: at pc=0x3000_0010 with isJump=1, isBranchEq=1, eqIn=1, target=26'h40 → next pc=0x3000_0100, taken=1.
- Stall then halt:
  - stall=1 for 4 cycles at pc=0x40 → pc, retireCount and state unchanged; taken=0 despite isJump=1.
  - Then isHalt=1 → halted=1, fetchValid=0; pc stays 0x40 for 10 cycles while flags toggle.
- Async reset mid-run: assert rst_n=0 between clock edges at pc=0x5C → pc=RESET_PC and retireCount=0 immediately, before the next edge. Wrap check: pc=0xFFFF_FFFC with no flags → next pc=0x0.

Source files
------------

// File: rtl/pc_branch_unit.sv
// ---------------------------------------------------------------------------
// pc_branch_unit
//
// Program counter and branch resolution for the single-cycle processor.
// Takes the decoded BEQ/BNE/J/HALT flags and the equality bit from the
// `equals` comparator, and produces the next fetch address every cycle.
// It also counts retired instructions. This is the only clocked state in the
// fetch path, and instruction memory is addressed directly from pc.
//
// Ports
//   clk          rising-edge system clock
//   rst_n        asynchronous active-low reset
//   stall        when high, pc, state and retire counter all hold
//   isBranchEq   decoded BEQ
//   isBranchNe   decoded BNE
//   isJump       decoded J
//   isHalt       decoded HALT
//   eqIn         equality result for the current instruction
//   offset       sign-extended word offset (WIDTH bits)
//   target       26-bit jump target field
//   pc           current fetch address
//   pcPlus4      pc + 4, combinational, wraps modulo 2^WIDTH
//   fetchValid   high while pc addresses a live instruction (RUN state)
//   taken        a branch or jump redirects the PC this cycle
//   halted       high in the HALTED state
//   retireCount  saturating count of instructions retired since reset
// ---------------------------------------------------------------------------
module pc_branch_unit #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_PC  = '0,
   parameter int unsigned      CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 stall,
   input  logic                 isBranchEq,
   input  logic                 isBranchNe,
   input  logic                 isJump,
   input  logic                 isHalt,
   input  logic                 eqIn,
   input  logic [WIDTH-1:0]     offset,
   input  logic [25:0]          target,
   output logic [WIDTH-1:0]     pc,
   output logic [WIDTH-1:0]     pcPlus4,
   output logic                 fetchValid,
   output logic                 taken,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] retireCount
);

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     pc_q, pc_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0]     branchTarget;
   logic [WIDTH-1:0]     jumpTarget;
   logic                 eqTaken;
   logic                 neTaken;
   logic                 runActive;

   // Candidate addresses and branch conditions. The jump keeps the top bits
   // of pc+4 (the current region), which is why it is built from pcPlus4
   // rather than from pc. All additions wrap silently at WIDTH bits.
   always_comb begin
      pcPlus4      = pc_q + WIDTH'(4);
      branchTarget = pcPlus4 + (offset << 2);
      jumpTarget   = {pcPlus4[WIDTH-1:28], target, 2'b00};
      eqTaken      = isBranchEq & eqIn;
      neTaken      = isBranchNe & ~eqIn;
      runActive    = (state_q == RUN) & ~stall;
      taken        = runActive & ~isHalt & (isJump | eqTaken | neTaken);
   end

   // Next-state selection. Halt has the highest priority, then jump, then the
   // two conditional branches (BEQ is checked before BNE), then fall-through.
   // The retire counter also counts the halt instruction and sticks at
   // all-ones rather than wrapping.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (!stall) begin
               if (cnt_q != '1) begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
               if (isHalt) begin
                  state_d = HALTED;
               end else if (isJump) begin
                  pc_d = jumpTarget;
               end else if (eqTaken || neTaken) begin
                  pc_d = branchTarget;
               end else begin
                  pc_d = pcPlus4;
               end
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // The only clocked process. Reset acts immediately, so nothing from a
   // cycle that was in progress when rst_n fell can survive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Status outputs are decoded directly from the registered state.
   always_comb begin
      pc          = pc_q;
      retireCount = cnt_q;
      fetchValid  = (state_q == RUN);
      halted      = (state_q == HALTED);
   end

endmodule

// File: tb/tb_pc_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_branch_unit
//
// Directed testbench for pc_branch_unit with a scoreboard. The driver applies
// one vector per cycle, just after the rising edge. With each vector it
// pushes the hand-computed outputs the design should show during that
// cycle. A monitor on the falling edge pops each entry and compares it with
// the design outputs.
// ---------------------------------------------------------------------------
module tb_pc_branch_unit;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        isBranchEq;
   logic        isBranchNe;
   logic        isJump;
   logic        isHalt;
   logic        eqIn;
   logic [31:0] offset;
   logic [25:0] target;
   logic [31:0] pc;
   logic [31:0] pcPlus4;
   logic        fetchValid;
   logic        taken;
   logic        halted;
   logic [31:0] retireCount;

   typedef struct {
      int          id;
      logic [31:0] pc;
      logic        taken;
      logic        fetchValid;
      logic        halted;
      logic [31:0] cnt;
   } expT;

   expT scoreboard[$];
   int  checks = 0;
   int  errors = 0;
   int  vecId  = 0;

   pc_branch_unit #(
      .WIDTH(32),
      .RESET_PC(32'h0000_0000),
      .CNT_WIDTH(32)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .stall(stall),
      .isBranchEq(isBranchEq),
      .isBranchNe(isBranchNe),
      .isJump(isJump),
      .isHalt(isHalt),
      .eqIn(eqIn),
      .offset(offset),
      .target(target),
      .pc(pc),
      .pcPlus4(pcPlus4),
      .fetchValid(fetchValid),
      .taken(taken),
      .halted(halted),
      .retireCount(retireCount)
   );

   // Free-running clock with a 10 ns period. The first rising edge is at 5 ns.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit, so the bench can never hang.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish before 100000", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Compares one output field and keeps the running totals.
   task automatic checkOutput(input string name, input int id,
                              input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s (vector %0d): got %h, expected %h", name, id, actual, expected);
      end
   endtask

   // Drives one cycle of inputs, records what the outputs should be during
   // that cycle, then advances to just after the next rising edge.
   task automatic applyStimulus(input logic rstN, input logic stl,
                                input logic beq, input logic bne,
                                input logic jmp, input logic hlt, input logic eq,
                                input logic [31:0] off, input logic [25:0] tgt,
                                input logic [31:0] ePc, input logic eTaken,
                                input logic eFv, input logic eHalted,
                                input logic [31:0] eCnt);
      expT e;
      rst_n      = rstN;
      stall      = stl;
      isBranchEq = beq;
      isBranchNe = bne;
      isJump     = jmp;
      isHalt     = hlt;
      eqIn       = eq;
      offset     = off;
      target     = tgt;
      vecId++;
      e.id         = vecId;
      e.pc         = ePc;
      e.taken      = eTaken;
      e.fetchValid = eFv;
      e.halted     = eHalted;
      e.cnt        = eCnt;
      scoreboard.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: on every falling edge, check the oldest expected entry against
   // the design outputs.
   always @(negedge clk) begin
      expT e;
      if (scoreboard.size() > 0) begin
         e = scoreboard.pop_front();
         checkOutput("pc",          e.id, pc,                 e.pc);
         checkOutput("pcPlus4",     e.id, pcPlus4,            e.pc + 32'd4);
         checkOutput("taken",       e.id, {31'd0, taken},      {31'd0, e.taken});
         checkOutput("fetchValid",  e.id, {31'd0, fetchValid}, {31'd0, e.fetchValid});
         checkOutput("halted",      e.id, {31'd0, halted},     {31'd0, e.halted});
         checkOutput("retireCount", e.id, retireCount,        e.cnt);
      end
   end

   initial begin
      rst_n      = 1'b0;
      stall      = 1'b0;
      isBranchEq = 1'b0;
      isBranchNe = 1'b0;
      isJump     = 1'b0;
      isHalt     = 1'b0;
      eqIn       = 1'b0;
      offset     = '0;
      target     = '0;
      @(posedge clk);
      #1;

      $display("[TB] reset and boot");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0,0,0,0,0,0, 32'd0, 26'd0,  32'h0, 0,0,0, 32'd0);
      end
      // BOOT cycle: stall and jump must both be ignored
      applyStimulus(1, 1,0,0,1,0,0, 32'd0, 26'h3F,    32'h0, 0,0,0, 32'd0);
      applyStimulus(1, 0,0,0,0,0,0, 32'd0, 26'd0,     32'h0, 0,1,0, 32'd0);
      applyStimulus(1, 0,0,0,0,0,0, 32'd0, 26'd0,     32'h4, 0,1,0, 32'd1);

      $display("[TB] BEQ taken / not taken");
      applyStimulus(1, 0,1,0,0,0,1, 32'd3, 26'd0,          32'h8,  1,1,0, 32'd2);
      applyStimulus(1, 0,1,0,0,0,1, 32'hFFFF_FFFB, 26'd0,  32'h18, 1,1,0, 32'd3);
      applyStimulus(1, 0,1,0,0,0,0, 32'd3, 26'd0,          32'h8,  0,1,0, 32'd4);

      $display("[TB] BNE forward / backward");
      applyStimulus(1, 0,0,1,0,0,0, 32'd4, 26'd0,          32'hC,  1,1,0, 32'd5);
      applyStimulus(1, 0,0,1,0,0,0, 32'hFFFF_FFFC, 26'd0,  32'h20, 1,1,0, 32'd6);
      applyStimulus(1, 0,0,0,1,0,0, 32'd0, 26'h8,          32'h14, 1,1,0, 32'd7);
      applyStimulus(1, 0,0,1,0,0,1, 32'hFFFF_FFFC, 26'd0,  32'h20, 0,1,0, 32'd8);

      $display("[TB] flag conflicts and jump priority");
      applyStimulus(1, 0,1,1,0,0,1, 32'd2, 26'd0,          32'h24, 1,1,0, 32'd9);
      applyStimulus(1, 0,1,0,0,0,1, 32'h0BFF_FFF7, 26'd0,  32'h30, 1,1,0, 32'd10);
      applyStimulus(1, 0,1,0,1,0,1, 32'd3, 26'h40,         32'h3000_0010, 1,1,0, 32'd11);
      applyStimulus(1, 0,1,0,0,0,1, 32'hF3FF_FFCF, 26'd0,  32'h3000_0100, 1,1,0, 32'd12);

      $display("[TB] stall then halt");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1,0,0,1,0,0, 32'd0, 26'h99,      32'h40, 0,1,0, 32'd13);
      end
      applyStimulus(1, 0,0,0,0,1,0, 32'd0, 26'd0,         32'h40, 0,1,0, 32'd13);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, i[2], i[1], ~i[1], i[0], i[3], i[0], 32'd5, 26'h12,
                       32'h40, 0,0,1, 32'd14);
      end

      $display("[TB] asynchronous reset mid-run");
      applyStimulus(0, 0,0,0,0,0,0, 32'd0, 26'd0,         32'h0,  0,0,0, 32'd0);
      applyStimulus(1, 0,0,0,0,0,0, 32'd0, 26'd0,         32'h0,  0,0,0, 32'd0);
      applyStimulus(1, 0,0,0,1,0,0, 32'd0, 26'h17,        32'h0,  1,1,0, 32'd0);
      applyStimulus(1, 1,0,0,0,0,0, 32'd0, 26'd0,         32'h5C, 0,1,0, 32'd1);
      applyStimulus(0, 0,0,0,0,0,0, 32'd0, 26'd0,         32'h0,  0,0,0, 32'd0);

      $display("[TB] PC wrap");
      applyStimulus(1, 0,0,0,0,0,0, 32'd0, 26'd0,         32'h0,  0,0,0, 32'd0);
      applyStimulus(1, 0,1,0,0,0,1, 32'hFFFF_FFFE, 26'd0, 32'h0,  1,1,0, 32'd0);
      applyStimulus(1, 0,0,0,0,0,0, 32'd0, 26'd0,         32'hFFFF_FFFC, 0,1,0, 32'd1);
      applyStimulus(1, 0,0,0,0,0,0, 32'd0, 26'd0,         32'h0,  0,1,0, 32'd2);

      @(negedge clk);
      #1;
      checks++;
      if (scoreboard.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", scoreboard.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
